// File: rtl/tlc_phase_scheduler.sv
// Traffic-light phase scheduler: main road rests in green, side-road and
// pedestrian requests are latched and served in round-robin order.
module tlc_phase_scheduler #(
    parameter int MIN_GREEN  = 10,
    parameter int MAX_GREEN  = 40,
    parameter int SR_MIN     = 5,
    parameter int SR_MAX     = 20,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 2,
    parameter int PED_T      = 8,
    parameter int CAR_THRESH = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] MR_cars,
    input  logic       SR_req,
    input  logic       PED_req,
    output logic [2:0] MR_ctl,
    output logic [2:0] SR_ctl,
    output logic       PED_walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_MR_G = 3'd0,
        S_MR_Y = 3'd1,
        S_AR_X = 3'd2,
        S_SR_G = 3'd3,
        S_SR_Y = 3'd4,
        S_PED  = 3'd5,
        S_AR_M = 3'd6,
        S_BAD  = 3'd7
    } state_t;

    // Last timer value of each timed state (a state of length T ends at T-1).
    localparam logic [7:0] MG_LAST    = 8'(MIN_GREEN - 1);
    localparam logic [7:0] MX_LAST    = 8'(MAX_GREEN - 1);
    localparam logic [7:0] SRMIN_LAST = 8'(SR_MIN - 1);
    localparam logic [7:0] SRMAX_LAST = 8'(SR_MAX - 1);
    localparam logic [7:0] Y_LAST     = 8'(YELLOW_T - 1);
    localparam logic [7:0] AR_LAST    = 8'(ALLRED_T - 1);
    localparam logic [7:0] PED_LAST   = 8'(PED_T - 1);
    localparam logic [8:0] CAR_TH     = 9'(CAR_THRESH);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] timer;
    logic       sr_pend;
    logic       ped_pend;
    logic       rr;
    logic       cars_low;
    logic       any_pend;
    logic       enter_sr;
    logic       enter_ped;
    logic [6:0] lamps_nxt;

    // Packs {MR_ctl, SR_ctl, PED_walk} for a given state.
    function automatic logic [6:0] lamp_decode(input state_t s);
        logic [6:0] l;
        l = {3'b100, 3'b100, 1'b0};
        case (s)
            S_MR_G:  l = {3'b001, 3'b100, 1'b0};
            S_MR_Y:  l = {3'b010, 3'b100, 1'b0};
            S_SR_G:  l = {3'b100, 3'b001, 1'b0};
            S_SR_Y:  l = {3'b100, 3'b010, 1'b0};
            S_PED:   l = {3'b100, 3'b100, 1'b1};
            default: l = {3'b100, 3'b100, 1'b0};
        endcase
        return l;
    endfunction

    assign cars_low  = ({1'b0, MR_cars} < CAR_TH);
    assign any_pend  = sr_pend | ped_pend;
    assign enter_sr  = (state_nxt == S_SR_G) && (state != S_SR_G);
    assign enter_ped = (state_nxt == S_PED) && (state != S_PED);
    assign lamps_nxt = lamp_decode(state_nxt);
    assign phase     = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_MR_G: begin
                if (any_pend && (((timer >= MG_LAST) && cars_low) || (timer == MX_LAST)))
                    state_nxt = S_MR_Y;
            end
            S_MR_Y: begin
                if (timer == Y_LAST)
                    state_nxt = S_AR_X;
            end
            S_AR_X: begin
                if (timer == AR_LAST) begin
                    // With both pending, rr names the one served last time.
                    if (ped_pend && (!sr_pend || !rr))
                        state_nxt = S_PED;
                    else if (sr_pend)
                        state_nxt = S_SR_G;
                    else
                        state_nxt = S_AR_M;
                end
            end
            S_SR_G: begin
                if (((timer >= SRMIN_LAST) && !SR_req) || (timer == SRMAX_LAST))
                    state_nxt = S_SR_Y;
            end
            S_SR_Y: begin
                if (timer == Y_LAST)
                    state_nxt = S_AR_M;
            end
            S_PED: begin
                if (timer == PED_LAST)
                    state_nxt = S_AR_M;
            end
            S_AR_M: begin
                if (timer == AR_LAST)
                    state_nxt = S_MR_G;
            end
            default: state_nxt = S_MR_G;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_MR_G;
            timer    <= 8'd0;
            sr_pend  <= 1'b0;
            ped_pend <= 1'b0;
            rr       <= 1'b0;
            MR_ctl   <= 3'b001;
            SR_ctl   <= 3'b100;
            PED_walk <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                timer <= 8'd0;
            else if (timer != 8'hFF)
                timer <= timer + 8'd1;

            sr_pend <= enter_sr ? 1'b0 : (sr_pend | SR_req);
            // Button presses while walking are absorbed by the walk itself.
            ped_pend <= (enter_ped || (state == S_PED)) ? 1'b0 : (ped_pend | PED_req);

            if (enter_ped)
                rr <= 1'b1;
            else if (enter_sr)
                rr <= 1'b0;

            MR_ctl   <= lamps_nxt[6:4];
            SR_ctl   <= lamps_nxt[3:1];
            PED_walk <= lamps_nxt[0];
        end
    end

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Bench for tlc_phase_scheduler: directed timelines plus random traffic,
// all compared every cycle against a phase-level reference model.
module tb_tlc_phase_scheduler;

    localparam int MIN_GREEN  = 10;
    localparam int MAX_GREEN  = 40;
    localparam int SR_MIN     = 5;
    localparam int SR_MAX     = 20;
    localparam int YELLOW_T   = 3;
    localparam int ALLRED_T   = 2;
    localparam int PED_T      = 8;
    localparam int CAR_THRESH = 20;

    localparam int P_MR_G = 0, P_MR_Y = 1, P_AR_X = 2, P_SR_G = 3;
    localparam int P_SR_Y = 4, P_PED = 5, P_AR_M = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] MR_cars;
    logic       SR_req;
    logic       PED_req;
    logic [2:0] MR_ctl;
    logic [2:0] SR_ctl;
    logic       PED_walk;
    logic [2:0] phase;

    always #5 clk = ~clk;

    tlc_phase_scheduler dut (
        .clk     (clk),
        .rst     (rst),
        .MR_cars (MR_cars),
        .SR_req  (SR_req),
        .PED_req (PED_req),
        .MR_ctl  (MR_ctl),
        .SR_ctl  (SR_ctl),
        .PED_walk(PED_walk),
        .phase   (phase)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: current phase, cycles already spent in it, latched requests.
    int m_ph;
    int m_dwell;
    bit m_sp;
    bit m_pp;
    bit m_rr;
    bit m_valid = 1'b0;

    int dph[$];
    int mph[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mr_lamp(input int ph);
        case (ph)
            P_MR_G:  return 1;
            P_MR_Y:  return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int sr_lamp(input int ph);
        case (ph)
            P_SR_G:  return 1;
            P_SR_Y:  return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int duration(input int ph);
        case (ph)
            P_MR_Y, P_SR_Y:  return YELLOW_T;
            P_AR_X, P_AR_M:  return ALLRED_T;
            P_PED:           return PED_T;
            default:         return 0;
        endcase
    endfunction

    task automatic model_step(input bit r, input int cars, input bit s, input bit p);
        int  nx;
        int  spent;
        if (r) begin
            m_ph = P_MR_G; m_dwell = 0; m_sp = 0; m_pp = 0; m_rr = 0; m_valid = 1'b1;
            return;
        end
        // Cycles completed in this phase once the current one ends (timer saturates).
        spent = ((m_dwell > 255) ? 255 : m_dwell) + 1;
        nx = m_ph;
        case (m_ph)
            P_MR_G:
                if ((m_sp || m_pp) &&
                    ((spent >= MIN_GREEN && cars < CAR_THRESH) || spent == MAX_GREEN))
                    nx = P_MR_Y;
            P_MR_Y: if (spent == duration(m_ph)) nx = P_AR_X;
            P_AR_X:
                if (spent == duration(m_ph)) begin
                    if (m_pp && (!m_sp || !m_rr)) nx = P_PED;
                    else if (m_sp)                nx = P_SR_G;
                    else                          nx = P_AR_M;
                end
            P_SR_G:
                if ((spent >= SR_MIN && !s) || spent == SR_MAX) nx = P_SR_Y;
            P_SR_Y, P_PED: if (spent == duration(m_ph)) nx = P_AR_M;
            P_AR_M: if (spent == duration(m_ph)) nx = P_MR_G;
            default: nx = P_MR_G;
        endcase
        if (nx == P_SR_G && m_ph != P_SR_G) m_sp = 0; else m_sp = m_sp | s;
        if ((nx == P_PED && m_ph != P_PED) || m_ph == P_PED) m_pp = 0; else m_pp = m_pp | p;
        if (nx == P_PED && m_ph != P_PED) m_rr = 1;
        else if (nx == P_SR_G && m_ph != P_SR_G) m_rr = 0;
        m_dwell = (nx != m_ph) ? 0 : m_dwell + 1;
        m_ph = nx;
    endtask

    // One clock: compare outputs at the falling edge, then apply inputs for the next rise.
    task automatic tick(input bit r, input int cars, input bit s, input bit p);
        @(negedge clk);
        if (m_valid) begin
            chk("phase",    phase,    m_ph);
            chk("mr_ctl",   MR_ctl,   mr_lamp(m_ph));
            chk("sr_ctl",   SR_ctl,   sr_lamp(m_ph));
            chk("ped_walk", PED_walk, (m_ph == P_PED) ? 1 : 0);
            chk("mr_onehot", $onehot(MR_ctl), 1);
            chk("sr_onehot", $onehot(SR_ctl), 1);
            chk("no_conflict", (MR_ctl != 3'b100) && (SR_ctl != 3'b100), 0);
            chk("walk_red", PED_walk && !(MR_ctl == 3'b100 && SR_ctl == 3'b100), 0);
            dph.push_back(int'(phase));
            mph.push_back(m_ph);
        end
        rst     = r;
        MR_cars = 8'(cars);
        SR_req  = s;
        PED_req = p;
        model_step(r, cars, s, p);
    endtask

    task automatic lit(input string name, input int idx, input int exp);
        if (idx >= dph.size()) begin
            chk({name, "_missing"}, idx, dph.size());
        end else begin
            chk({name, "_dut"}, dph[idx], exp);
            chk({name, "_mdl"}, mph[idx], exp);
        end
    endtask

    initial begin
        int  base;
        bit  sr_lvl;
        int  cars;
        rst = 1'b1; MR_cars = 8'd0; SR_req = 1'b0; PED_req = 1'b0;

        // Idle: main road green throughout.
        tick(1, 0, 0, 0);
        base = dph.size();
        for (int k = 0; k < 100; k++) tick(0, 0, 0, 0);
        lit("idle_c0", base, P_MR_G);
        lit("idle_c99", base + 99, P_MR_G);

        // Side-road request with an empty main road.
        tick(1, 0, 0, 0);
        base = dph.size();
        for (int k = 0; k < 36; k++) tick(0, 0, (k < 25), 0);
        lit("sr_c9",  base + 9,  P_MR_G);
        lit("sr_c10", base + 10, P_MR_Y);
        lit("sr_c13", base + 13, P_AR_X);
        lit("sr_c15", base + 15, P_SR_G);
        lit("sr_c25", base + 25, P_SR_G);
        lit("sr_c26", base + 26, P_SR_Y);
        lit("sr_c29", base + 29, P_AR_M);
        lit("sr_c31", base + 31, P_MR_G);

        // Heavy main road: green held to MAX_GREEN, side green to SR_MAX.
        tick(1, 0, 0, 0);
        base = dph.size();
        for (int k = 0; k < 70; k++) tick(0, 30, 1, 0);
        lit("max_c39", base + 39, P_MR_G);
        lit("max_c40", base + 40, P_MR_Y);
        lit("max_c45", base + 45, P_SR_G);
        lit("max_c64", base + 64, P_SR_G);
        lit("max_c65", base + 65, P_SR_Y);

        // Contention: pedestrian first, then side road first on the repeat.
        tick(1, 0, 0, 0);
        base = dph.size();
        for (int k = 0; k < 75; k++) tick(0, 0, (k == 0), (k == 0 || k == 18 || k == 27));
        lit("rr_c14", base + 14, P_AR_X);
        lit("rr_c15", base + 15, P_PED);
        lit("rr_c22", base + 22, P_PED);
        lit("rr_c23", base + 23, P_AR_M);
        lit("rr_c25", base + 25, P_MR_G);
        lit("rr_c40", base + 40, P_SR_G);
        lit("rr_c50", base + 50, P_MR_G);
        lit("rr_c65", base + 65, P_PED);

        // Reset mid side-yellow, with requests asserted during the reset cycle.
        tick(1, 0, 0, 0);
        base = dph.size();
        for (int k = 0; k < 21; k++) tick(0, 0, (k < 15), 0);
        tick(1, 0, 1, 1);
        for (int k = 0; k < 30; k++) tick(0, 0, 0, 0);
        lit("rst_c21", base + 21, P_SR_Y);
        lit("rst_c22", base + 22, P_MR_G);
        lit("rst_c45", base + 45, P_MR_G);

        // Random traffic.
        sr_lvl = 1'b0;
        cars = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 19) == 0) sr_lvl = ~sr_lvl;
            if ($urandom_range(0, 29) == 0) cars = $urandom_range(0, 40);
            tick(($urandom_range(0, 399) == 0), cars, sr_lvl, ($urandom_range(0, 49) == 0));
        end
        tick(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tlc_phase_scheduler.md
TLC_PHASE_SCHEDULER -- requirements
Module: tlc_phase_scheduler

Interface
REQ-001 Parameter MIN_GREEN, default 10: minimum main-road green, cycles (1..255).
REQ-002 Parameter MAX_GREEN, default 40: maximum main-road green while a request is pending, cycles (MIN_GREEN..255).
REQ-003 Parameter SR_MIN, default 5: minimum side-road green, cycles.
REQ-004 Parameter SR_MAX, default 20: maximum side-road green, cycles.
REQ-005 Parameter YELLOW_T, default 3: yellow duration, cycles.
REQ-006 Parameter ALLRED_T, default 2: all-red clearance duration, cycles.
REQ-007 Parameter PED_T, default 8: pedestrian walk duration, cycles.
REQ-008 Parameter CAR_THRESH, default 20: main-road queue size at or above which main green is held until MAX_GREEN.
REQ-009 clk  in  1  single system clock; all logic on its rising edge.
REQ-010 rst  in  1  synchronous reset, active-high.
REQ-011 MR_cars  in  8  unsigned count of cars queued on the main road.
REQ-012 SR_req  in  1  side-road vehicle sensor, level.
REQ-013 PED_req  in  1  pedestrian button, pulse of one or more cycles.
REQ-014 MR_ctl  out  3  main-road lamp {R,Y,G}, one-hot, registered.
REQ-015 SR_ctl  out  3  side-road lamp {R,Y,G}, one-hot, registered.
REQ-016 PED_walk  out  1  pedestrian walk lamp, registered.
REQ-017 phase  out  3  current state encoding, registered.

Function
REQ-018 States and phase codes SHALL be: MR_G=0, MR_Y=1, AR_X=2, SR_G=3, SR_Y=4, PED=5, AR_M=6; code 7 is illegal and SHALL return to MR_G on the next cycle.
REQ-019 Outputs SHALL be Moore-decoded from the state register: MR_G -> MR 001/SR 100; MR_Y -> MR 010/SR 100; SR_G -> MR 100/SR 001; SR_Y -> MR 100/SR 010; AR_X, AR_M, PED -> MR 100/SR 100; PED_walk=1 only in PED.
REQ-020 An 8-bit dwell timer SHALL clear to 0 on every state change and otherwise increment; a timed state of duration T SHALL exit when timer==T-1, so it lasts exactly T cycles.
REQ-021 sr_pend SHALL be set by SR_req=1 and cleared on entry to SR_G; ped_pend SHALL be set by PED_req=1 and cleared on entry to PED; PED_req during PED or on the entry edge SHALL be absorbed.
REQ-022 MR_G -> MR_Y when (sr_pend or ped_pend) and either (timer>=MIN_GREEN-1 and MR_cars<CAR_THRESH) or timer==MAX_GREEN-1; with no pending request MR_G SHALL hold indefinitely, timer saturating at 255.
REQ-023 MR_Y -> AR_X after YELLOW_T.
REQ-024 AR_X -> after ALLRED_T: PED if only ped_pend; SR_G if only sr_pend; if both pending, the one not indicated by the round-robin bit rr (rr=0: PED first; rr=1: SR_G first).
REQ-025 rr SHALL be set to 1 on entry to PED and to 0 on entry to SR_G.
REQ-026 SR_G -> SR_Y when (timer>=SR_MIN-1 and SR_req=0) or timer==SR_MAX-1.
REQ-027 SR_Y -> AR_M after YELLOW_T; PED -> AR_M after PED_T; AR_M -> MR_G after ALLRED_T.
REQ-028 A request still pending on return to MR_G SHALL be served by the normal MR_G rule; no state other than MR_G SHALL be skipped.
REQ-029 MR and SR SHALL never both be non-red; PED_walk=1 SHALL imply MR=SR=100.

Reset
REQ-030 With rst=1 at a clock edge the block SHALL, on that edge, enter MR_G with timer=0, sr_pend=0, ped_pend=0, rr=0, MR_ctl=001, SR_ctl=100, PED_walk=0, phase=0, from any state including mid-sequence.
REQ-031 Inputs sampled during reset SHALL be ignored; requests must be reasserted after rst falls.

Verification (default parameters)
REQ-032 Reset, all requests 0 for 100 cycles -> MR_ctl=001, SR_ctl=100, phase=0 throughout.
REQ-033 SR_req=1 from first post-reset cycle, MR_cars=0 -> MR_G 10 cycles, MR_Y 3, AR_X 2, SR_G from cycle 15; SR_req=0 at cycle 25 -> SR_Y at cycle 26, AR_M, MR_G at cycle 31.
REQ-034 MR_cars=30, SR_req=1 held -> MR_G lasts exactly 40 cycles; SR_G lasts exactly 20 cycles (SR_MAX).
REQ-035 PED_req pulse and SR_req=1 together after reset -> PED (walk=1, 8 cycles) served first, SR_G on the next cycle of service; a repeated contention then serves SR first.
REQ-036 rst=1 for one cycle while phase=4 (SR_Y) -> next cycle MR_ctl=001, SR_ctl=100, pending flags 0.
REQ-037 Every run: checker asserts REQ-029 and one-hot MR_ctl/SR_ctl on every cycle.
